// File: rtl/beta_sched.sv
// beta_sched: sequencer for the turbo decoder's backward (beta) recursion.
// Presets the beta unit, walks gamma memory backwards (optional termination
// tail steps, then block steps K-1..0) and strobes each finished beta vector
// into beta storage two cycles after its gamma read.
// Optional feature: define TURBO_TAIL_EN to include the TAIL state
// (TAIL_LEN termination steps before the block steps); undefined, gam_tail is 0.
//
// Handshake: start is a one-cycle request that is only accepted while the FSM
// is in IDLE or DONE (busy=0); an accepted request is answered by exactly one
// done pulse, a rejected one (illegal blk_len) by exactly one cfg_err pulse,
// and a start seen while busy=1 is dropped without any response.
module beta_sched #(
    parameter int K_MAX    = 6144,
    parameter int K_MIN    = 40,
    parameter int AW       = 13,
    parameter int TAIL_LEN = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] blk_len,
    output logic          beta_init,
    output logic          gam_rd_en,
    output logic          gam_tail,
    output logic [AW-1:0] gam_addr,
    output logic          beta_we,
    output logic [AW-1:0] beta_waddr,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [2:0]    dbg_state
);

`ifdef TURBO_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TAIL  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q;
    logic [AW-1:0] k_q;
    logic [AW-1:0] addr_q;
    logic          rd_en_q;
    logic          tail_q;
    logic          flush_q;
    logic          busy_q;
    logic          done_q;
    logic          init_q;
    logic          err_q;

    // read pipeline: stage 1 = beta unit inputs, stage 2 = write strobe
    logic          pipe_v_q;
    logic [AW-1:0] pipe_a_q;
    logic          we_q;
    logic [AW-1:0] waddr_q;

    logic          len_ok_d;

    // Legal block length check on the raw input, used only on an accepted start
    always_comb begin
        len_ok_d = (blk_len >= AW'(K_MIN)) && (blk_len <= AW'(K_MAX));
    end

    // Schedule FSM: all schedule outputs are registered in the same process
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            tail_q  <= 1'b0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            init_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                // DONE behaves like IDLE so back-to-back blocks need no gap
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    init_q  <= 1'b1;
                    rd_en_q <= 1'b0;
                    tail_q  <= 1'b0;
                    addr_q  <= '0;
                    if (start) begin
                        if (len_ok_d) begin
                            k_q     <= blk_len;
                            init_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            rd_en_q <= 1'b1;
                            if (TAIL_EN) begin
                                state_q <= S_TAIL;
                                tail_q  <= 1'b1;
                                addr_q  <= AW'(TAIL_LEN - 1);
                            end else begin
                                state_q <= S_RUN;
                                addr_q  <= blk_len - AW'(1);
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                // tail steps flow straight into the block steps with no bubble
                S_TAIL: begin
                    if (addr_q == '0) begin
                        state_q <= S_RUN;
                        tail_q  <= 1'b0;
                        addr_q  <= k_q - AW'(1);
                    end else begin
                        addr_q <= addr_q - AW'(1);
                    end
                end
                S_RUN: begin
                    if (addr_q == '0) begin
                        state_q <= S_FLUSH;
                        rd_en_q <= 1'b0;
                        flush_q <= 1'b0;
                    end else begin
                        addr_q <= addr_q - AW'(1);
                    end
                end
                // two drain cycles let the last two beta vectors be written
                S_FLUSH: begin
                    if (flush_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        init_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    init_q  <= 1'b1;
                    rd_en_q <= 1'b0;
                    tail_q  <= 1'b0;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    // Track block reads through the beta unit; tail results are never stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_q <= 1'b0;
            pipe_a_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
        end else begin
            pipe_v_q <= rd_en_q & ~tail_q;
            pipe_a_q <= addr_q;
            we_q     <= pipe_v_q;
            waddr_q  <= pipe_v_q ? pipe_a_q : '0;
        end
    end

    assign beta_init  = init_q;
    assign gam_rd_en  = rd_en_q;
`ifdef TURBO_TAIL_EN
    assign gam_tail   = tail_q;
`else
    assign gam_tail   = 1'b0;
`endif
    assign gam_addr   = addr_q;
    assign beta_we    = we_q;
    assign beta_waddr = waddr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_beta_sched.sv
// Bench for beta_sched: directed and random block requests; a schedule model
// built from the start-to-output timing rules fills expected queues that a
// negedge monitor drains against the DUT outputs.
`timescale 1ns/1ps
module tb_beta_sched;

    localparam int AW    = 13;
    localparam int K_MIN = 40;
    localparam int K_MAX = 6144;
`ifdef TURBO_TAIL_EN
    localparam int T = 3;
`else
    localparam int T = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] blk_len = '0;
    logic          beta_init;
    logic          gam_rd_en;
    logic          gam_tail;
    logic [AW-1:0] gam_addr;
    logic          beta_we;
    logic [AW-1:0] beta_waddr;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [2:0]    dbg_state;

    beta_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .blk_len    (blk_len),
        .beta_init  (beta_init),
        .gam_rd_en  (gam_rd_en),
        .gam_tail   (gam_tail),
        .gam_addr   (gam_addr),
        .beta_we    (beta_we),
        .beta_waddr (beta_waddr),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [45:0] rd_q[$];    // {cycle, tail, addr}
    logic [44:0] wr_q[$];    // {cycle, addr}
    logic [31:0] done_q[$];  // cycle
    logic [31:0] err_q[$];   // cycle

    int total = 0;
    int bad = 0;
    int run_lo = 1;
    int run_hi = 0;
    int free_at = 0;
    int last_s = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input longint act);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected no event (cycle %0d)", name, act, cyc);
    endtask

    // Whole-block schedule derived from the start cycle s and block length k
    task automatic model_accept(input int s, input int k);
        for (int j = 0; j < T; j++)
            rd_q.push_back({32'(s + 1 + j), 1'b1, 13'(T - 1 - j)});
        for (int i = 0; i < k; i++) begin
            rd_q.push_back({32'(s + T + 1 + i), 1'b0, 13'(k - 1 - i)});
            wr_q.push_back({32'(s + T + 3 + i), 13'(k - 1 - i)});
        end
        done_q.push_back(32'(s + T + k + 3));
        run_lo  = s + 1;
        run_hi  = s + T + k + 2;
        free_at = s + T + k + 3;
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic goto_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic issue(input int len);
        last_s  = cyc;
        start   = 1'b1;
        blk_len = AW'(len);
        if (cyc >= free_at) begin
            if (len >= K_MIN && len <= K_MAX) model_accept(cyc, len);
            else err_q.push_back(32'(cyc + 1));
        end
        @(negedge clk);
        start   = 1'b0;
        blk_len = AW'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_beta_init"}, beta_init, 1);
        check({tag, "_gam_rd_en"}, gam_rd_en, 0);
        check({tag, "_gam_tail"}, gam_tail, 0);
        check({tag, "_gam_addr"}, gam_addr, 0);
        check({tag, "_beta_we"}, beta_we, 0);
        check({tag, "_beta_waddr"}, beta_waddr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [45:0] r;
        logic [44:0] w;
        logic [31:0] c;
        logic        exp_busy;
        if (mon_en) begin
            exp_busy = (cyc >= run_lo) && (cyc <= run_hi);
            check("busy", busy, exp_busy);
            check("beta_init", beta_init, !exp_busy);

            // expected events whose cycle has passed without the DUT showing them
            while (rd_q.size() > 0 && int'(rd_q[0][45:14]) < cyc) begin
                r = rd_q.pop_front();
                flag("rd_missing_addr", r[12:0]);
            end
            while (wr_q.size() > 0 && int'(wr_q[0][44:13]) < cyc) begin
                w = wr_q.pop_front();
                flag("wr_missing_addr", w[12:0]);
            end
            while (done_q.size() > 0 && int'(done_q[0]) < cyc) begin
                c = done_q.pop_front();
                flag("done_missing_cycle", c);
            end
            while (err_q.size() > 0 && int'(err_q[0]) < cyc) begin
                c = err_q.pop_front();
                flag("cfg_err_missing_cycle", c);
            end

            if (gam_rd_en) begin
                if (rd_q.size() == 0) flag("rd_unexpected_addr", gam_addr);
                else begin
                    r = rd_q.pop_front();
                    check("rd_cycle", cyc, r[45:14]);
                    check("rd_tail", gam_tail, r[13]);
                    check("rd_addr", gam_addr, r[12:0]);
                end
            end
            if (beta_we) begin
                if (wr_q.size() == 0) flag("wr_unexpected_addr", beta_waddr);
                else begin
                    w = wr_q.pop_front();
                    check("wr_cycle", cyc, w[44:13]);
                    check("wr_addr", beta_waddr, w[12:0]);
                end
            end
            if (done) begin
                if (done_q.size() == 0) flag("done_unexpected", cyc);
                else begin
                    c = done_q.pop_front();
                    check("done_cycle", cyc, c);
                end
            end
            if (cfg_err) begin
                if (err_q.size() == 0) flag("cfg_err_unexpected", cyc);
                else begin
                    c = err_q.pop_front();
                    check("cfg_err_cycle", cyc, c);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n  = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;

        // idle hold with no start
        goto_cycle(cyc + 20);

        // nominal K=40, then a second block started in the DONE cycle
        issue(40);
        goto_cycle(free_at);
        issue(40);

        // starts during a run are ignored (legal and illegal length)
        goto_cycle(last_s + 10);
        issue(50);
        issue(39);
        goto_cycle(free_at + 3);

        // illegal lengths
        issue(39);
        goto_cycle(cyc + 3);
        issue(6145);
        goto_cycle(cyc + 3);
        issue(0);
        goto_cycle(cyc + 2);

        // longest block
        issue(6144);
        goto_cycle(free_at + 2);

        // asynchronous reset in the middle of a K=40 run
        issue(40);
        goto_cycle(last_s + 20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        err_q.delete();
        run_lo  = 1;
        run_hi  = 0;
        free_at = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        issue(40);
        goto_cycle(free_at + 2);

        // random traffic: mixed lengths, stray starts, back-to-back or gapped
        for (int n = 0; n < 30; n++) begin
            int len;
            int sel;
            int gap;
            sel = $urandom_range(0, 9);
            if (sel == 0) len = $urandom_range(0, 39);
            else if (sel == 1) len = $urandom_range(6145, 8191);
            else len = $urandom_range(40, 160);
            issue(len);
            if ($urandom_range(0, 2) == 0 && cyc + 2 < free_at) begin
                goto_cycle(cyc + $urandom_range(1, 10));
                issue($urandom_range(0, 8191));
            end
            gap = $urandom_range(0, 3);
            goto_cycle(free_at + gap);
        end

        goto_cycle(free_at + 5);
        check("rd_q_left", rd_q.size(), 0);
        check("wr_q_left", wr_q.size(), 0);
        check("done_q_left", done_q.size(), 0);
        check("err_q_left", err_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beta_sched.md
# beta_sched

Sequencer for the turbo decoder's backward (beta) recursion. It drives the beta recursion unit's active-high init/preset input. It also walks the branch-metric (gamma) memory backwards: optional trellis-termination tail steps first, then block steps K-1 down to 0. Each resulting beta vector gets a write strobe and address into beta storage. The block sits between the decoder top-level control (start/done handshake) and the beta datapath plus its gamma and beta RAMs.

## Interface
- K_MAX, 6144, largest supported block length
- K_MIN, 40, smallest supported block length
- AW, 13, address width of gamma/beta memories (2^AW > K_MAX)
- TAIL_LEN, 3, number of termination steps
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle request to run one block; honoured only when idle
- blk_len  in  AW  block length K, sampled on the accepted start
- beta_init  out  1  registered; high = beta unit held at initial metrics
- gam_rd_en  out  1  gamma memory read strobe
- gam_tail  out  1  1 = gam_addr indexes tail metrics, 0 = block metrics
- gam_addr  out  AW  gamma read address
- beta_we  out  1  beta storage write strobe
- beta_waddr  out  AW  beta storage write address
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, run finished
- cfg_err  out  1  one-cycle pulse, start rejected for illegal blk_len

## Operation
- All outputs are registered.
- Reset values:
  - beta_init=1.
  - All other outputs 0.
  - FSM in IDLE.
- States: IDLE, TAIL, RUN, FLUSH, DONE.
- IDLE:
  - beta_init=1.
  - On start, if K_MIN<=blk_len<=K_MAX: latch K, drop beta_init, go to TAIL (or to RUN when tail is compiled out). In both cases the first read address is issued in the next cycle.
  - On start with an out-of-range blk_len: pulse cfg_err for one cycle and stay in IDLE.
- TAIL:
  - gam_tail=1.
  - gam_addr steps TAIL_LEN-1 down to 0, one per cycle.
  - beta_we stays 0 for tail steps.
  - Then RUN.
- RUN:
  - gam_tail=0.
  - gam_addr steps K-1 down to 0, one per cycle, with gam_rd_en=1.
  - After address 0, go to FLUSH.
- FLUSH:
  - Two cycles.
  - gam_rd_en=0 while the pipeline drains.
- DONE:
  - One cycle.
  - done=1, busy=0, beta_init=1.
  - A start in this cycle is accepted exactly as in IDLE (back-to-back blocks). beta_init is already high, so the unit is preset.
- Pipeline:
  - A read issued in cycle c reaches the beta unit inputs in cycle c+1.
  - The beta registers update at the end of c+1.
  - For a RUN address a issued in cycle c: beta_we=1 and beta_waddr=a in cycle c+2.
- The beta datapath has no enable. The schedule is therefore strictly continuous: no stall and no bubble between the last tail step and the first RUN step.
- beta_init never toggles while busy=1.
- start while busy=1 is ignored; no error is flagged.
- Address counters are AW bits and count down only; no wrap below 0 occurs.
- Reset mid-run:
  - Outputs return to reset values immediately (asynchronous).
  - No done pulse.
  - Latched K is discarded.

## Timing
- Accepted start at cycle 0 edge; T = TAIL_LEN if tail is compiled in, else 0.
- Cycle 1: beta_init=0, busy=1, first gam_rd_en.
- Reads: cycles 1..T+K.
- Writes: cycles T+3..T+K+2; the first write is address K-1, the last is address 0.
- busy: high cycles 1..T+K+2.
- done: cycle T+K+3.
- Start-to-done latency: T+K+3 cycles.
- Minimum start-to-start period: T+K+3 cycles.
- cfg_err: the cycle after the rejected start.

## Configuration
- TURBO_TAIL_EN defined:
  - TAIL state is present and T=TAIL_LEN.
  - Recursion starts from the termination tail metrics.
- TURBO_TAIL_EN undefined:
  - TAIL state and gam_tail logic are removed; gam_tail is tied 0.
  - T=0 and RUN begins directly from the initial beta_init metrics.

## Test plan
- Reset:
  - Assert rst_n=0 mid-clock -> beta_init=1 and all other outputs 0 immediately.
  - Release reset, no start -> IDLE held indefinitely.
- Nominal block, TURBO_TAIL_EN, K=40, start at cycle 0:
  - gam_tail=1 with addresses 2,1,0 in cycles 1-3.
  - Addresses 39..0 in cycles 4-43.
  - beta_we with waddr 39..0 in cycles 6-45.
  - done in cycle 46.
- TURBO_TAIL_EN undefined, K=6144:
  - First read address 6143 in cycle 1.
  - Last write address 0 in cycle 6146.
  - done in cycle 6147.
- Illegal length:
  - blk_len=39 -> cfg_err in cycle 1, busy stays 0, no reads.
  - blk_len=6145 -> same response.
- Back-to-back and overlap:
  - start asserted during the run -> ignored.
  - start in the DONE cycle of a K=40 run -> second run's first read in the next cycle, with correct tail/block sequence.
- Reset mid-run:
  - rst_n=0 at cycle 20 of a K=40 run -> no further beta_we and no done.
  - Subsequent start runs cleanly from the beginning.
